fetch_bundle_queue: RTL and testbench
=====================================

// Module: fetch_bundle_queue
// PURPOSE
//  Decoupling queue directly downstream of fetch stage 1; buffers whole fetch bundles
//  (PC, 4 instructions, per-slot BTB hit/prediction/target, RAS checkpoint) for fetch stage 2/decode.
//  Absorbs decode back-pressure so fetch-1 keeps fetching until the queue fills.
//  Raises a stall back to fetch-1 when full. Empties in one cycle on any pipeline recovery.
// PARAMETERS
//  DEPTH        4   number of bundle entries (>=2, power of two not required)
//  SIZE_PC      32  PC / target address width
//  INST_WIDTH   32  bits per instruction
//  FETCH_WIDTH  4   instructions per bundle (bundle = FETCH_WIDTH*INST_WIDTH bits)
// PORTS
//  clk              in   1                      clock, all state on rising edge
//  reset            in   1                      asynchronous, active-low reset
//  flush_i          in   1                      recovery/exception flush; empties queue
//  enqValid_i       in   1                      fetch-1 presents a bundle (fs1Ready & ~stall)
//  enqPC_i          in   SIZE_PC                bundle PC
//  enqBundle_i      in   FETCH_WIDTH*INST_WIDTH instructions, slot 0 in LSBs
//  enqBtbHit_i      in   FETCH_WIDTH            per-slot BTB hit
//  enqPred_i        in   FETCH_WIDTH            per-slot direction prediction
//  enqTarget_i      in   FETCH_WIDTH*SIZE_PC    per-slot target, slot 0 in LSBs
//  enqRasCP_i       in   SIZE_PC                RAS checkpoint address
//  full_o           out  1                      queue full; fetch-1 must stall
//  deqReady_i       in   1                      consumer takes head bundle this cycle
//  deqValid_o       out  1                      head entry valid
//  deqPC_o .. deqRasCP_o  out  (as enq)         head entry fields, same layout as enq side
//  count_o          out  $clog2(DEPTH+1)        current occupancy
// BEHAVIOUR
//  - Reset (reset==0, async): head=tail=0, count=0; deqValid_o=0, full_o=0, count_o=0.
//    Storage array not reset; deq data fields are don't-care while deqValid_o=0.
//  - enqAccept = enqValid_i & ~full_o; deqAccept = deqReady_i & deqValid_o.
//  - full_o = (count==DEPTH); deqValid_o = (count!=0); both from registered count only,
//    no combinational path from enq/deq inputs to any output.
//  - Enqueue: write entry at tail, tail advances; visible at head one cycle later at the earliest.
//    No bypass; an enqueue into an empty queue gives deqValid_o=1 on the next cycle.
//  - Dequeue: head advances; head entry drives deq* combinationally from storage.
//  - Pointers wrap explicitly DEPTH-1 -> 0.
//  - Same cycle enq and deq: count unchanged, both pointers advance.
//  - Enq while full (enqValid_i=1, full_o=1): bundle dropped, state unchanged; fetch-1 holds
//    its PC on full_o, so the bundle is re-presented. Same-cycle deq at full does not free a
//    slot for that cycle's enq.
//  - flush_i=1: next state head=tail=count=0, overriding any enq/deq in the same cycle.
//  - Async reset mid-operation discards all contents, same state as power-on reset.
//  - count arithmetic: count_next = count + enqAccept - deqAccept, width $clog2(DEPTH+1);
//    it never goes outside 0..DEPTH.
// STRUCTURE
//  - Shared package: FETCH_WIDTH, SIZE_PC, INST_WIDTH, a packed fetch-bundle struct
//    (pc, insts, btbHit, pred, targets, rasCP) reused by fetch-1 output and this queue.
//  - One sub-module: fetch_queue_ram, DEPTH x bundle-width storage;
//    1 sync write port, 1 async read port.
//  - Pointer/count control stays in the top level.
// TESTING
//  - Reset: deassert reset after 3 cycles -> deqValid_o=0, full_o=0, count_o=0.
//  - Fill/drain: deqReady=0, enqueue PCs 0x100,0x120,0x140,0x160 -> full_o=1, count_o=4.
//    Then deqReady=1 -> PCs emerge in that order, deqValid_o falls after the 4th.
//  - Simultaneous enq/deq at count=2 for 10 cycles -> count_o stays 2.
//    Data order preserved across pointer wrap.
//  - Enq while full with PC 0x180 -> dropped; count_o stays 4; 0x180 never appears at output.
//  - flush_i with enqValid_i=1 and deqReady_i=1 at count=3 -> next cycle count_o=0,
//    deqValid_o=0, flushed/enqueued bundle never appears.
//  - Field integrity: slot2 btbHit=1, pred=1, target=0xDEAD0000 -> identical at
//    deq outputs, slots 0/1/3 unaffected.

Source files
------------

// File: rtl/fetch_bundle_queue_pkg.sv
// Shared fetch-bundle definitions used by fetch stage 1 and the fetch bundle queue.
// One bundle = PC, FETCH_WIDTH instructions, per-slot BTB hit/prediction/target, RAS checkpoint.
package fetch_bundle_queue_pkg;

  localparam int FETCH_WIDTH = 4;
  localparam int SIZE_PC     = 32;
  localparam int INST_WIDTH  = 32;

  typedef struct packed {
    logic [SIZE_PC-1:0]             pc;
    logic [FETCH_WIDTH*INST_WIDTH-1:0] insts;
    logic [FETCH_WIDTH-1:0]         btbHit;
    logic [FETCH_WIDTH-1:0]         pred;
    logic [FETCH_WIDTH*SIZE_PC-1:0] targets;
    logic [SIZE_PC-1:0]             rasCP;
  } fetch_bundle_t;

  localparam int BUNDLE_W = $bits(fetch_bundle_t);

endpackage

// File: rtl/fetch_queue_ram.sv
// Bundle storage for the fetch bundle queue: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module fetch_queue_ram
  import fetch_bundle_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  fetch_bundle_t     wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output fetch_bundle_t     rdata_o
);

  fetch_bundle_t mem_q [DEPTH];

  // Write the tail entry on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_bundle_queue.sv
// Decoupling queue between fetch stage 1 and fetch stage 2/decode. Absorbs decode
// back-pressure, raises full_o to stall fetch-1, and empties in one cycle on flush_i.
module fetch_bundle_queue
  import fetch_bundle_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic                              enqValid_i,
  input  logic [SIZE_PC-1:0]                enqPC_i,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] enqBundle_i,
  input  logic [FETCH_WIDTH-1:0]            enqBtbHit_i,
  input  logic [FETCH_WIDTH-1:0]            enqPred_i,
  input  logic [FETCH_WIDTH*SIZE_PC-1:0]    enqTarget_i,
  input  logic [SIZE_PC-1:0]                enqRasCP_i,
  output logic                              full_o,
  input  logic                              deqReady_i,
  output logic                              deqValid_o,
  output logic [SIZE_PC-1:0]                deqPC_o,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] deqBundle_o,
  output logic [FETCH_WIDTH-1:0]            deqBtbHit_o,
  output logic [FETCH_WIDTH-1:0]            deqPred_o,
  output logic [FETCH_WIDTH*SIZE_PC-1:0]    deqTarget_o,
  output logic [SIZE_PC-1:0]                deqRasCP_o,
  output logic [CNT_W-1:0]                  count_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_accept_s;
  logic             deq_accept_s;
  fetch_bundle_t    enq_bundle_s;
  fetch_bundle_t    head_bundle_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Status comes only from the registered count, so no input reaches an output combinationally.
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign deqValid_o = (count_q != {CNT_W{1'b0}});
  assign count_o    = count_q;

  assign enq_accept_s = enqValid_i & ~full_o;
  assign deq_accept_s = deqReady_i & deqValid_o;

  assign enq_bundle_s.pc      = enqPC_i;
  assign enq_bundle_s.insts   = enqBundle_i;
  assign enq_bundle_s.btbHit  = enqBtbHit_i;
  assign enq_bundle_s.pred    = enqPred_i;
  assign enq_bundle_s.targets = enqTarget_i;
  assign enq_bundle_s.rasCP   = enqRasCP_i;

  // Next-state pointers and occupancy; flush overrides any same-cycle enq/deq.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (enq_accept_s) begin
        tail_d = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (deq_accept_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + CNT_W'(enq_accept_s) - CNT_W'(deq_accept_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fetch_queue_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (enq_accept_s & ~flush_i),
    .waddr_i (tail_q),
    .wdata_i (enq_bundle_s),
    .raddr_i (head_q),
    .rdata_o (head_bundle_s)
  );

  assign deqPC_o     = head_bundle_s.pc;
  assign deqBundle_o = head_bundle_s.insts;
  assign deqBtbHit_o = head_bundle_s.btbHit;
  assign deqPred_o   = head_bundle_s.pred;
  assign deqTarget_o = head_bundle_s.targets;
  assign deqRasCP_o  = head_bundle_s.rasCP;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Self-checking bench for fetch_bundle_queue: a reference queue of expected bundles is
// pushed on accepted enqueues and popped/compared on accepted dequeues.
module tb_fetch_bundle_queue;
  import fetch_bundle_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                              clk;
  logic                              reset;
  logic                              flush_i;
  logic                              enqValid_i;
  logic [SIZE_PC-1:0]                enqPC_i;
  logic [FETCH_WIDTH*INST_WIDTH-1:0] enqBundle_i;
  logic [FETCH_WIDTH-1:0]            enqBtbHit_i;
  logic [FETCH_WIDTH-1:0]            enqPred_i;
  logic [FETCH_WIDTH*SIZE_PC-1:0]    enqTarget_i;
  logic [SIZE_PC-1:0]                enqRasCP_i;
  logic                              full_o;
  logic                              deqReady_i;
  logic                              deqValid_o;
  logic [SIZE_PC-1:0]                deqPC_o;
  logic [FETCH_WIDTH*INST_WIDTH-1:0] deqBundle_o;
  logic [FETCH_WIDTH-1:0]            deqBtbHit_o;
  logic [FETCH_WIDTH-1:0]            deqPred_o;
  logic [FETCH_WIDTH*SIZE_PC-1:0]    deqTarget_o;
  logic [SIZE_PC-1:0]                deqRasCP_o;
  logic [CNT_W-1:0]                  count_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int seen_180     = 0;
  fetch_bundle_t model_q[$];

  fetch_bundle_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .enqValid_i  (enqValid_i),
    .enqPC_i     (enqPC_i),
    .enqBundle_i (enqBundle_i),
    .enqBtbHit_i (enqBtbHit_i),
    .enqPred_i   (enqPred_i),
    .enqTarget_i (enqTarget_i),
    .enqRasCP_i  (enqRasCP_i),
    .full_o      (full_o),
    .deqReady_i  (deqReady_i),
    .deqValid_o  (deqValid_o),
    .deqPC_o     (deqPC_o),
    .deqBundle_o (deqBundle_o),
    .deqBtbHit_o (deqBtbHit_o),
    .deqPred_o   (deqPred_o),
    .deqTarget_o (deqTarget_o),
    .deqRasCP_o  (deqRasCP_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic fetch_bundle_t make_bundle(input logic [31:0] pc);
    fetch_bundle_t b;
    b.pc      = pc;
    b.insts   = {$urandom, $urandom, $urandom, $urandom};
    b.btbHit  = 4'($urandom);
    b.pred    = 4'($urandom);
    b.targets = {$urandom, $urandom, $urandom, $urandom};
    b.rasCP   = $urandom;
    return b;
  endfunction

  // One cycle: apply inputs after the falling edge, check state against the model, update model.
  task automatic step(input logic enq, input fetch_bundle_t b, input logic deq, input logic flush);
    fetch_bundle_t exp_b;
    int  cnt;
    logic enq_acc, deq_acc;
    enqValid_i  = enq;
    enqPC_i     = b.pc;
    enqBundle_i = b.insts;
    enqBtbHit_i = b.btbHit;
    enqPred_i   = b.pred;
    enqTarget_i = b.targets;
    enqRasCP_i  = b.rasCP;
    deqReady_i  = deq;
    flush_i     = flush;
    #1;
    cnt = model_q.size();
    check_eq("count", 128'(count_o), 128'(cnt));
    check_eq("full", 128'(full_o), 128'(cnt == DEPTH));
    check_eq("valid", 128'(deqValid_o), 128'(cnt != 0));
    if (deqValid_o === 1'b1 && deqPC_o === 32'h180) seen_180++;
    enq_acc = enq && (cnt != DEPTH);
    deq_acc = deq && (cnt != 0);
    if (deq_acc) begin
      exp_b = model_q.pop_front();
      check_eq("deq_pc", 128'(deqPC_o), 128'(exp_b.pc));
      check_eq("deq_insts", 128'(deqBundle_o), 128'(exp_b.insts));
      check_eq("deq_btb", 128'(deqBtbHit_o), 128'(exp_b.btbHit));
      check_eq("deq_pred", 128'(deqPred_o), 128'(exp_b.pred));
      check_eq("deq_tgt", 128'(deqTarget_o), 128'(exp_b.targets));
      check_eq("deq_ras", 128'(deqRasCP_o), 128'(exp_b.rasCP));
    end
    if (enq_acc) model_q.push_back(b);
    if (flush) model_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  fetch_bundle_t nb;
  fetch_bundle_t fb;

  initial begin
    reset = 1'b0;
    nb = make_bundle(32'h0);
    step(1'b0, nb, 1'b0, 1'b0);
    step(1'b0, nb, 1'b0, 1'b0);
    step(1'b0, nb, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, nb, 1'b0, 1'b0);

    // Fill to full, then attempt 0x180 while full (alone, then with a same-cycle dequeue).
    for (int i = 0; i < 4; i++) step(1'b1, make_bundle(32'h100 + 32'(i) * 32'h20), 1'b0, 1'b0);
    step(1'b1, make_bundle(32'h180), 1'b0, 1'b0);
    step(1'b1, make_bundle(32'h180), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, nb, 1'b1, 1'b0);

    // Steady state at count 2 across pointer wrap.
    step(1'b1, make_bundle(32'h200), 1'b0, 1'b0);
    step(1'b1, make_bundle(32'h220), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, make_bundle(32'h240 + 32'(i) * 32'h20), 1'b1, 1'b0);
    check_eq("steady_count", 128'(count_o), 128'd2);
    step(1'b0, nb, 1'b1, 1'b0);
    step(1'b0, nb, 1'b1, 1'b0);

    // Flush at count 3 with simultaneous enq/deq.
    for (int i = 0; i < 3; i++) step(1'b1, make_bundle(32'h400 + 32'(i) * 32'h20), 1'b0, 1'b0);
    step(1'b1, make_bundle(32'h480), 1'b1, 1'b1);
    check_eq("flush_count", 128'(count_o), 128'd0);
    check_eq("flush_valid", 128'(deqValid_o), 128'd0);
    step(1'b0, nb, 1'b1, 1'b0);

    // Field integrity: only slot 2 carries a hit/prediction/target.
    fb = '0;
    fb.pc = 32'h500;
    fb.btbHit = 4'b0100;
    fb.pred = 4'b0100;
    fb.targets[2*SIZE_PC +: SIZE_PC] = 32'hDEAD0000;
    step(1'b1, fb, 1'b0, 1'b0);
    #1;
    check_eq("slot2_hit", 128'(deqBtbHit_o[2]), 128'd1);
    check_eq("slot2_pred", 128'(deqPred_o[2]), 128'd1);
    check_eq("slot2_tgt", 128'(deqTarget_o[2*SIZE_PC +: SIZE_PC]), 128'h0DEAD0000);
    check_eq("slot013_hit", 128'({deqBtbHit_o[3], deqBtbHit_o[1:0]}), 128'd0);
    check_eq("slot0_tgt", 128'(deqTarget_o[0 +: SIZE_PC]), 128'd0);
    check_eq("slot3_tgt", 128'(deqTarget_o[3*SIZE_PC +: SIZE_PC]), 128'd0);
    step(1'b0, nb, 1'b1, 1'b0);

    // Asynchronous reset mid-operation discards contents.
    step(1'b1, make_bundle(32'h600), 1'b0, 1'b0);
    step(1'b1, make_bundle(32'h620), 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_count", 128'(count_o), 128'd0);
    check_eq("async_rst_valid", 128'(deqValid_o), 128'd0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, nb, 1'b0, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 99) < 60), make_bundle(32'h1000 + 32'(i) * 32'h20),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3));
    end
    for (int i = 0; i < 5; i++) step(1'b0, nb, 1'b1, 1'b0);

    check_eq("pc180_never_out", 128'(seen_180), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
